// File: rtl/alu_acc_pkg.sv
// ---------------------------------------------------------------------------
// alu_acc_pkg
// Shared types and constants for the alu_acc_ctrl accumulator sequencer and
// its alu_4bit datapath.
//   cmd_op_e  : 3-bit command opcode seen on the command channel
//   state_e   : sequencer FSM states
//   ALU_*     : 2-bit operation codes understood by alu_4bit
//   alu_op_of : maps a command opcode onto the ALU operation it needs
// ---------------------------------------------------------------------------
package alu_acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_MUL  = 3'b110,
    OP_CLR  = 3'b111
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Opcodes that do not use the ALU result (NOP/LOAD/CLR/MUL in EXEC) fall
  // back to ADD; their result is ignored by the sequencer.
  function automatic logic [1:0] alu_op_of(input cmd_op_e op);
    logic [1:0] r;
    case (op)
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_acc_ctrl_alu4.sv
// ---------------------------------------------------------------------------
// alu_4bit
// Purely combinational 4-bit ALU shared by the accumulator sequencer.
//   a, b   in  : operands
//   op     in  : ALU_ADD / ALU_SUB / ALU_AND / ALU_OR
//   result out : a op b, modulo 16
//   zero   out : result == 0
//   carry  out : ADD -> carry out of bit 3; SUB -> borrow (a < b);
//                AND/OR -> 0
// ---------------------------------------------------------------------------
module alu_4bit
  import alu_acc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] result,
  output logic       zero,
  output logic       carry
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;

  // 5-bit extended arithmetic: bit 4 is carry-out for ADD and borrow for SUB.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = 4'h0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        result = w_sum[3:0];
        carry  = w_sum[4];
      end
      ALU_SUB: begin
        result = w_diff[3:0];
        carry  = w_diff[4];
      end
      ALU_AND: result = a & b;
      default: result = a | b;
    endcase
  end

  assign zero = (result == 4'h0);

endmodule

// File: rtl/alu_acc_ctrl.sv
// ---------------------------------------------------------------------------
// alu_acc_ctrl
// Command-driven 4-bit accumulator sequencer; initiator of alu_4bit.
// One command in flight at a time; the response holds the accumulator and
// flags until it is accepted.
//
// Build option: define ALU_ACC_MUL_EN to enable opcode 110 (MUL), a
// shift-free repeated-add multiply acc * cmd_data taking cmd_data+1 cycles
// with a sticky overflow carry. Without it, opcode 110 acts as a NOP and
// reports rsp_err = 1.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready command channel handshake (ready only in IDLE)
//   cmd_op, cmd_data    opcode (see alu_acc_pkg::cmd_op_e) and operand
//   rsp_valid/rsp_ready response channel handshake
//   rsp_acc             accumulator after the command
//   rsp_zero, rsp_carry flags after the command
//   rsp_err             opcode not supported by this build
//   busy                sequencer is not in IDLE
// ---------------------------------------------------------------------------
module alu_acc_ctrl
  import alu_acc_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] ACC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_acc,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy
);

  // The datapath is bound to alu_4bit; any other width must not build.
  if (DATA_W != 4) begin : g_bad_width
    $error("alu_acc_ctrl: DATA_W must be 4 to match alu_4bit");
  end

  state_e            r_state;
  cmd_op_e           r_op;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_acc;
  logic              r_zero;
  logic              r_carry;
  logic              r_err;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_busy;
`ifdef ALU_ACC_MUL_EN
  localparam logic [DATA_W-1:0] ONE = 1;
  logic [DATA_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_prod;
`endif

  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [1:0]        w_alu_op;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_zero;
  logic              w_alu_carry;
  logic              w_accept;

  assign w_accept = cmd_valid && r_cmd_ready;

  // ALU operand steering; inputs are parked at zero outside EXEC/MUL.
  always_comb begin
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_op = ALU_ADD;
    case (r_state)
      ST_EXEC: begin
        w_alu_a  = r_acc;
        w_alu_b  = r_operand;
        w_alu_op = alu_op_of(r_op);
      end
`ifdef ALU_ACC_MUL_EN
      ST_MUL: begin
        // Repeated addition: prod += acc, once per remaining count.
        w_alu_a  = r_prod;
        w_alu_b  = r_acc;
        w_alu_op = ALU_ADD;
      end
`endif
      default: ;
    endcase
  end

  alu_4bit u_alu (
    .a      (w_alu_a),
    .b      (w_alu_b),
    .op     (w_alu_op),
    .result (w_alu_result),
    .zero   (w_alu_zero),
    .carry  (w_alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_operand   <= '0;
      r_acc       <= ACC_INIT;
      r_zero      <= (ACC_INIT == '0);
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ALU_ACC_MUL_EN
      r_cnt       <= '0;
      r_prod      <= '0;
`endif
    end else begin
      case (r_state)
        // ---- IDLE: accept and latch one command ----
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op_e'(cmd_op);
            r_operand   <= cmd_data;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef ALU_ACC_MUL_EN
            r_err       <= 1'b0;
            if (cmd_op_e'(cmd_op) == OP_MUL) begin
              r_state <= ST_MUL;
              r_cnt   <= cmd_data;
              r_prod  <= '0;
              r_carry <= 1'b0;
            end else begin
              r_state <= ST_EXEC;
            end
`else
            // MUL is not built: it runs as a NOP and is flagged as an error.
            r_err       <= (cmd_op_e'(cmd_op) == OP_MUL);
            r_state     <= ST_EXEC;
`endif
          end
        end

        // ---- EXEC: single-cycle ALU / register update ----
        ST_EXEC: begin
          case (r_op)
            OP_LOAD: begin
              r_acc   <= r_operand;
              r_zero  <= (r_operand == '0);
              r_carry <= 1'b0;
            end
            OP_ADD, OP_SUB: begin
              r_acc   <= w_alu_result;
              r_zero  <= w_alu_zero;
              r_carry <= w_alu_carry;
            end
            OP_AND, OP_OR: begin
              r_acc   <= w_alu_result;
              r_zero  <= w_alu_zero;
              r_carry <= 1'b0;
            end
            OP_CLR: begin
              r_acc   <= '0;
              r_zero  <= 1'b1;
              r_carry <= 1'b0;
            end
            default: ;  // NOP (and MUL when not built): state unchanged
          endcase
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
        end

`ifdef ALU_ACC_MUL_EN
        // ---- MUL: one addition per cycle until the count is exhausted ----
        ST_MUL: begin
          if (r_cnt == '0) begin
            r_acc       <= r_prod;
            r_zero      <= (r_prod == '0);
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_prod  <= w_alu_result;
            r_cnt   <= r_cnt - ONE;
            r_carry <= r_carry | w_alu_carry;  // sticky overflow
          end
        end
`endif

        // ---- RESP: hold response until the consumer takes it ----
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_acc   = r_acc;
  assign rsp_zero  = r_zero;
  assign rsp_carry = r_carry;
  assign rsp_err   = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_ctrl
// Self-checking bench for alu_acc_ctrl: reset values, a directed vector
// table, randomized commands against an arithmetic reference model,
// response backpressure and reset during an in-flight command.
// Build with +define+ALU_ACC_MUL_EN to exercise the MUL opcode.
// ---------------------------------------------------------------------------
module tb_alu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_acc;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_err;
  logic       busy;

  alu_acc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_acc   (rsp_acc),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_NOP = 3'd0, C_LOAD = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3,
                         C_AND = 3'd4, C_OR = 3'd5, C_MUL = 3'd6, C_CLR = 3'd7;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the accumulator and flags as plain integers.
  int m_acc, m_zero, m_carry;

  typedef struct {
    logic [2:0] op;
    logic [3:0] data;
    int         acc;
    int         zero;
    int         carry;
    int         err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: applies one command to the integer state, returns the
  // expected error flag and accept-to-response latency.
  task automatic model_step(input int op, input int d, output int err, output int lat);
    int s;
    err = 0;
    lat = 1;
    case (op)
      1: begin m_acc = d; m_carry = 0; end
      2: begin s = m_acc + d; m_carry = (s > 15); m_acc = s % 16; end
      3: begin m_carry = (m_acc < d); m_acc = (m_acc - d + 16) % 16; end
      4: begin m_acc = m_acc & d; m_carry = 0; end
      5: begin m_acc = m_acc | d; m_carry = 0; end
      6: begin
`ifdef ALU_ACC_MUL_EN
        s = m_acc * d;
        m_carry = (s > 15);
        m_acc = s % 16;
        lat = d + 1;
`else
        err = 1;
`endif
      end
      7: begin m_acc = 0; m_carry = 0; end
      default: ;
    endcase
    if (op != 0 && !(op == 6 && err == 1)) m_zero = (m_acc == 0);
  endtask

  // Issue one command, measure latency, hold the response for 'hold' cycles
  // checking stability, then accept it. Called #1 after a rising edge.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] d,
                         input int hold, output int acc, output int z, output int c,
                         output int e, output int lat);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cmd_ready_low"}, cmd_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    acc = rsp_acc;
    z   = rsp_zero;
    c   = rsp_carry;
    e   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_acc"}, rsp_acc, acc);
      check({tag, "_hold_flags"}, {rsp_zero, rsp_carry, rsp_err}, {z[0], c[0], e[0]});
      check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_post_rsp_valid"}, rsp_valid, 0);
    check({tag, "_post_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int acc, z, c, e, lat, xerr, xlat, seen;
    logic [2:0] rop;
    logic [3:0] rd;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_acc", rsp_acc, 0);
    check("reset_zero", rsp_zero, 1);
    check("reset_carry", rsp_carry, 0);
    check("reset_err", rsp_err, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    m_acc = 0; m_zero = 1; m_carry = 0;
    @(posedge clk); #1;

    // Directed vectors: {op, data, acc, zero, carry, err, latency}
    vecs.push_back('{C_LOAD, 4'd15, 15, 0, 0, 0, 1});
    vecs.push_back('{C_ADD,  4'd1,   0, 1, 1, 0, 1});
    vecs.push_back('{C_LOAD, 4'd12, 12, 0, 0, 0, 1});
    vecs.push_back('{C_AND,  4'd10,  8, 0, 0, 0, 1});
    vecs.push_back('{C_OR,   4'd3,  11, 0, 0, 0, 1});
    vecs.push_back('{C_SUB,  4'd12, 15, 0, 1, 0, 1});
    vecs.push_back('{C_SUB,  4'd15,  0, 1, 0, 0, 1});
    vecs.push_back('{C_LOAD, 4'd9,   9, 0, 0, 0, 1});
    vecs.push_back('{C_CLR,  4'd6,   0, 1, 0, 0, 1});
    vecs.push_back('{C_NOP,  4'd5,   0, 1, 0, 0, 1});
    vecs.push_back('{C_LOAD, 4'd3,   3, 0, 0, 0, 1});
`ifdef ALU_ACC_MUL_EN
    vecs.push_back('{C_MUL,  4'd5,  15, 0, 0, 0, 6});
    vecs.push_back('{C_LOAD, 4'd5,   5, 0, 0, 0, 1});
    vecs.push_back('{C_MUL,  4'd4,   4, 0, 1, 0, 5});
    vecs.push_back('{C_MUL,  4'd0,   0, 1, 0, 0, 1});
`else
    vecs.push_back('{C_MUL,  4'd5,   3, 0, 0, 1, 1});
    vecs.push_back('{C_LOAD, 4'd0,   0, 1, 0, 0, 1});
`endif

    foreach (vecs[i]) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, 0, acc, z, c, e, lat);
      model_step(vecs[i].op, vecs[i].data, xerr, xlat);
      check($sformatf("vec%0d_acc", i), acc, vecs[i].acc);
      check($sformatf("vec%0d_zero", i), z, vecs[i].zero);
      check($sformatf("vec%0d_carry", i), c, vecs[i].carry);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: response held for 3 cycles, then accepted.
    run_cmd("bp_load", C_LOAD, 4'd4, 0, acc, z, c, e, lat);
    model_step(C_LOAD, 4, xerr, xlat);
    run_cmd("bp_add", C_ADD, 4'd5, 3, acc, z, c, e, lat);
    model_step(C_ADD, 5, xerr, xlat);
    check("bp_acc", acc, 9);
    check("bp_flags", {z[0], c[0]}, 2'b00);

    // Randomized commands against the reference model.
    for (int k = 0; k < 150; k++) begin
      rop = 3'($urandom_range(0, 7));
      rd  = 4'($urandom_range(0, 15));
      run_cmd($sformatf("rnd%0d", k), rop, rd, $urandom_range(0, 2), acc, z, c, e, lat);
      model_step(rop, rd, xerr, xlat);
      check($sformatf("rnd%0d_op%0d_acc", k, rop), acc, m_acc);
      check($sformatf("rnd%0d_op%0d_zero", k, rop), z, m_zero);
      check($sformatf("rnd%0d_op%0d_carry", k, rop), c, m_carry);
      check($sformatf("rnd%0d_op%0d_err", k, rop), e, xerr);
      check($sformatf("rnd%0d_op%0d_latency", k, rop), lat, xlat);
    end

    // Reset three cycles after accepting MUL 9: command aborted, no response.
    run_cmd("rst_load", C_LOAD, 4'd7, 0, acc, z, c, e, lat);
    cmd_valid = 1'b1; cmd_op = C_MUL; cmd_data = 4'd9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_mul_accepted", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort_acc", rsp_acc, 0);
    check("rst_abort_zero", rsp_zero, 1);
    check("rst_abort_carry", rsp_carry, 0);
    check("rst_abort_rsp_valid", rsp_valid, 0);
    check("rst_abort_cmd_ready", cmd_ready, 1);
    check("rst_abort_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rst_no_response", seen, 0);
    m_acc = 0; m_zero = 1; m_carry = 0;
    run_cmd("post_rst_add", C_ADD, 4'd2, 0, acc, z, c, e, lat);
    check("post_rst_add_acc", acc, 2);
    check("post_rst_add_latency", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
